aq_ifu_btb_assoc: RTL and testbench
===================================

Name: aq_ifu_btb_assoc

Overview:
- Fully associative, parametrised branch target buffer for the IFU. Replaces the per-entry tag/target store used so far with an N-entry array.
- Each entry holds valid, tag, target and a saturating direction counter.
- Provides a one-cycle registered lookup, hit-update/miss-allocate training with round-robin replacement, and a single-cycle flush.
- Sits between the IFU PC generator (lookup) and the branch resolution path (update).

Parameters:
ENTRY_NUM, 8, number of entries; power of two, >= 2
TAG_WIDTH, 16, tag bits compared on lookup/update
TGT_WIDTH, 16, stored target bits
CNT_WIDTH, 2, direction counter width; counter MSB = predict taken
PTR_WIDTH, $clog2(ENTRY_NUM), replacement pointer width (derived, not overridden)

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  asynchronous active-low reset
cp0_ifu_btb_en  input  1  BTB enable; 0 forces lookup miss and blocks allocation
btb_inv_all  input  1  invalidate all entries
btb_rd_vld  input  1  lookup request
btb_rd_tag  input  TAG_WIDTH  lookup tag
btb_upd_vld  input  1  training request from branch resolution
btb_upd_tag  input  TAG_WIDTH  resolved branch tag
btb_upd_tgt  input  TGT_WIDTH  resolved target
btb_upd_taken  input  1  resolved direction
btb_rd_hit  output  1  registered lookup hit
btb_rd_taken  output  1  registered predicted direction (counter MSB); 0 on miss
btb_rd_tgt  output  TGT_WIDTH  registered target; 0 on miss
btb_upd_hit  output  1  registered: last update hit an existing entry

Behaviour:
- Clock and reset: one clock, forever_cpuclk. cpurst_b is asynchronous, active-low.
- Reset: all valid=0; tags, targets and counters=0; rr pointer=0; all outputs=0.
- Lookup, latency 1:
  - In cycle T, compare btb_rd_tag against every valid entry.
  - In T+1, btb_rd_hit/btb_rd_taken/btb_rd_tgt reflect the pre-update array contents of T.
  - If btb_rd_vld=0 or cp0_ifu_btb_en=0 in T, all three outputs are 0 in T+1.
  - Multiple hits cannot occur: the allocation rule below prevents duplicate tags.
- Update, evaluated in cycle T, state written at the T+1 edge:
  - Hit (valid entry whose tag equals btb_upd_tag):
    - taken: counter+1, saturating at all-ones; target <= btb_upd_tgt.
    - not taken: counter-1, saturating at 0; target unchanged.
    - btb_upd_hit=1 in T+1.
  - Miss and taken and cp0_ifu_btb_en=1:
    - Allocate the victim: the lowest-index invalid entry if one exists, else the entry at the rr pointer.
    - Victim gets valid=1, tag, target, and counter = weakly taken (MSB=1, other bits 0; 2'b10 at default).
    - The rr pointer increments, wrapping ENTRY_NUM-1 -> 0, only when a valid entry is replaced.
  - Miss and not taken: no state change.
  - In every non-hit case, btb_upd_hit=0 in T+1.
- Counter updates on a hit happen even when cp0_ifu_btb_en=0; only allocation is blocked.
- Invalidate: btb_inv_all in T clears all valid bits at the T+1 edge and resets the rr pointer to 0.
  - It has priority over a same-cycle update; that update is dropped and btb_upd_hit=0.
  - A same-cycle lookup still returns its result from the pre-invalidate state.
- Lookup and update to the same tag in the same cycle: the lookup returns the old entry; the new value is visible to a lookup one cycle later.
- Tags, targets and counters of invalid entries are don't-care and must never drive outputs.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the first post-reset lookup misses.
- Only the array and rr pointer are stateful; there is no FSM beyond the per-entry counters.

Test Plan:
- Reset, then lookup tag 0x1234 -> T+1: rd_hit=0, rd_tgt=0, rd_taken=0.
- Update tag 0x1234 tgt 0x5678 taken; lookup 0x1234 the next cycle -> rd_hit=1, rd_tgt=0x5678, rd_taken=1.
- Counter saturation:
  - Two not-taken updates on 0x1234 -> counter 0, rd_taken=0; a third not-taken update -> counter stays 0.
  - Four taken updates on 0x1234 -> counter 3, rd_taken=1.
- Replacement: fill 8 entries with tags 0..7, then allocate tag 8 -> entry 0 replaced; lookup 0 misses, lookup 8 hits; allocate tag 9 -> entry 1 replaced.
- Invalidate vs. update: btb_inv_all together with an update of tag 0xAAAA taken -> every subsequent lookup misses, including 0xAAAA; btb_upd_hit=0.
- Same-cycle ordering: lookup and taken update of a new tag 0x00FF in the same cycle -> rd_hit=0 in T+1; a lookup in T+1 -> hit in T+2. Also: with cp0_ifu_btb_en=0, a taken miss update does not allocate.

Source files
------------

// File: rtl/aq_ifu_btb_assoc_if.sv
// Lookup/training/control bundle between the IFU PC generator, branch resolution
// and the associative BTB.
interface aq_ifu_btb_assoc_if #(
  parameter int unsigned TAG_WIDTH = 16,
  parameter int unsigned TGT_WIDTH = 16
);
  logic                 cp0_ifu_btb_en;
  logic                 btb_inv_all;
  logic                 btb_rd_vld;
  logic [TAG_WIDTH-1:0] btb_rd_tag;
  logic                 btb_upd_vld;
  logic [TAG_WIDTH-1:0] btb_upd_tag;
  logic [TGT_WIDTH-1:0] btb_upd_tgt;
  logic                 btb_upd_taken;
  logic                 btb_rd_hit;
  logic                 btb_rd_taken;
  logic [TGT_WIDTH-1:0] btb_rd_tgt;
  logic                 btb_upd_hit;

  modport master (
    output cp0_ifu_btb_en, btb_inv_all,
    output btb_rd_vld, btb_rd_tag,
    output btb_upd_vld, btb_upd_tag, btb_upd_tgt, btb_upd_taken,
    input  btb_rd_hit, btb_rd_taken, btb_rd_tgt, btb_upd_hit
  );

  modport slave (
    input  cp0_ifu_btb_en, btb_inv_all,
    input  btb_rd_vld, btb_rd_tag,
    input  btb_upd_vld, btb_upd_tag, btb_upd_tgt, btb_upd_taken,
    output btb_rd_hit, btb_rd_taken, btb_rd_tgt, btb_upd_hit
  );
endinterface

// File: rtl/aq_ifu_btb_assoc.sv
// Fully associative BTB: registered lookup, hit-update / miss-allocate training
// with invalid-first then round-robin replacement, and single-cycle flush.
module aq_ifu_btb_assoc #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned TAG_WIDTH = 16,
  parameter int unsigned TGT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 2,
  localparam int unsigned PTR_WIDTH = $clog2(ENTRY_NUM)
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  aq_ifu_btb_assoc_if.slave   btb
);

  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_TAKEN = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q [ENTRY_NUM];
  logic [TAG_WIDTH-1:0] tag_d [ENTRY_NUM];
  logic [TGT_WIDTH-1:0] tgt_q [ENTRY_NUM];
  logic [TGT_WIDTH-1:0] tgt_d [ENTRY_NUM];
  logic [CNT_WIDTH-1:0] cnt_q [ENTRY_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [ENTRY_NUM];
  logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                 rd_hit_q, rd_hit_d;
  logic                 rd_taken_q, rd_taken_d;
  logic [TGT_WIDTH-1:0] rd_tgt_q, rd_tgt_d;
  logic                 upd_hit_q, upd_hit_d;

  logic [ENTRY_NUM-1:0] rd_match;
  logic [ENTRY_NUM-1:0] upd_match;
  logic                 rd_en;
  logic                 upd_hit_any;
  logic                 free_found;
  logic [PTR_WIDTH-1:0] free_idx;
  logic [PTR_WIDTH-1:0] victim_idx;
  logic                 alloc;

  always_comb begin
    rd_match  = '0;
    upd_match = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      rd_match[i]  = valid_q[i] && (tag_q[i] == btb.btb_rd_tag);
      upd_match[i] = valid_q[i] && (tag_q[i] == btb.btb_upd_tag);
    end
  end

  // Tags are unique, so at most one match bit is set and AND-OR muxing is exact.
  always_comb begin
    rd_en      = btb.btb_rd_vld && btb.cp0_ifu_btb_en;
    rd_hit_d   = rd_en && (|rd_match);
    rd_taken_d = 1'b0;
    rd_tgt_d   = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (rd_en && rd_match[i]) begin
        rd_taken_d = rd_taken_d | cnt_q[i][CNT_WIDTH-1];
        rd_tgt_d   = rd_tgt_d | tgt_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = PTR_WIDTH'(i);
      end
    end
    victim_idx = free_found ? free_idx : rr_ptr_q;
  end

  always_comb begin
    upd_hit_any = |upd_match;
    alloc       = btb.btb_upd_vld && !btb.btb_inv_all && !upd_hit_any &&
                  btb.btb_upd_taken && btb.cp0_ifu_btb_en;
  end

  // Flush wins over training; hit training ignores the enable, allocation does not.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    upd_hit_d = 1'b0;
    if (btb.btb_inv_all) begin
      valid_d  = '0;
      rr_ptr_d = '0;
    end else if (btb.btb_upd_vld && upd_hit_any) begin
      upd_hit_d = 1'b1;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        if (upd_match[i]) begin
          if (btb.btb_upd_taken) begin
            tgt_d[i] = btb.btb_upd_tgt;
            if (cnt_q[i] != '1) begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
          end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
          end
        end
      end
    end else if (alloc) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        if (victim_idx == PTR_WIDTH'(i)) begin
          valid_d[i] = 1'b1;
          tag_d[i]   = btb.btb_upd_tag;
          tgt_d[i]   = btb.btb_upd_tgt;
          cnt_d[i]   = CNT_WEAK_TAKEN;
        end
      end
      if (!free_found) begin
        rr_ptr_d = rr_ptr_q + PTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      valid_q    <= '0;
      rr_ptr_q   <= '0;
      rd_hit_q   <= 1'b0;
      rd_taken_q <= 1'b0;
      rd_tgt_q   <= '0;
      upd_hit_q  <= 1'b0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_hit_q   <= rd_hit_d;
      rd_taken_q <= rd_taken_d;
      rd_tgt_q   <= rd_tgt_d;
      upd_hit_q  <= upd_hit_d;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btb.btb_rd_hit   = rd_hit_q;
  assign btb.btb_rd_taken = rd_taken_q;
  assign btb.btb_rd_tgt   = rd_tgt_q;
  assign btb.btb_upd_hit  = upd_hit_q;

endmodule

// File: tb/tb_aq_ifu_btb_assoc.sv
// Directed scoreboard bench for aq_ifu_btb_assoc at default parameters.
module tb_aq_ifu_btb_assoc;

  logic forever_cpuclk = 1'b0;
  logic cpurst_b       = 1'b0;

  aq_ifu_btb_assoc_if #(.TAG_WIDTH(16), .TGT_WIDTH(16)) btb ();

  aq_ifu_btb_assoc #(
    .ENTRY_NUM(8),
    .TAG_WIDTH(16),
    .TGT_WIDTH(16),
    .CNT_WIDTH(2)
  ) dut (
    .forever_cpuclk(forever_cpuclk),
    .cpurst_b      (cpurst_b),
    .btb           (btb)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
    logic        uhit;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic cmp(input string name, input string field,
                     input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s got=%0h exp=%0h", name, field, got, exp);
    end
  endtask

  task automatic step(input string name, input logic en, input logic inv,
                      input logic rv, input logic [15:0] rtag,
                      input logic uv, input logic [15:0] utag,
                      input logic [15:0] utgt, input logic ut,
                      input logic eh, input logic et,
                      input logic [15:0] etgt, input logic euh);
    exp_t  e;
    string n;
    @(negedge forever_cpuclk);
    btb.cp0_ifu_btb_en = en;
    btb.btb_inv_all    = inv;
    btb.btb_rd_vld     = rv;
    btb.btb_rd_tag     = rtag;
    btb.btb_upd_vld    = uv;
    btb.btb_upd_tag    = utag;
    btb.btb_upd_tgt    = utgt;
    btb.btb_upd_taken  = ut;
    exp_q.push_back('{hit: eh, taken: et, tgt: etgt, uhit: euh});
    name_q.push_back(name);
    @(posedge forever_cpuclk);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    cmp(n, "rd_hit",   {15'd0, btb.btb_rd_hit},   {15'd0, e.hit});
    cmp(n, "rd_taken", {15'd0, btb.btb_rd_taken}, {15'd0, e.taken});
    cmp(n, "rd_tgt",   btb.btb_rd_tgt,            e.tgt);
    cmp(n, "upd_hit",  {15'd0, btb.btb_upd_hit},  {15'd0, e.uhit});
  endtask

  task automatic lookup(input string name, input logic [15:0] tag,
                        input logic eh, input logic et, input logic [15:0] etgt);
    step(name, 1'b1, 1'b0, 1'b1, tag, 1'b0, 16'h0, 16'h0, 1'b0, eh, et, etgt, 1'b0);
  endtask

  task automatic train(input string name, input logic [15:0] tag,
                       input logic [15:0] tgt, input logic tk, input logic euh);
    step(name, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, tag, tgt, tk, 1'b0, 1'b0, 16'h0, euh);
  endtask

  task automatic out_zero(input string name);
    cmp(name, "rd_hit",   {15'd0, btb.btb_rd_hit},   16'h0);
    cmp(name, "rd_taken", {15'd0, btb.btb_rd_taken}, 16'h0);
    cmp(name, "rd_tgt",   btb.btb_rd_tgt,            16'h0);
    cmp(name, "upd_hit",  {15'd0, btb.btb_upd_hit},  16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    btb.cp0_ifu_btb_en = 1'b1;
    btb.btb_inv_all    = 1'b0;
    btb.btb_rd_vld     = 1'b0;
    btb.btb_rd_tag     = '0;
    btb.btb_upd_vld    = 1'b0;
    btb.btb_upd_tag    = '0;
    btb.btb_upd_tgt    = '0;
    btb.btb_upd_taken  = 1'b0;
    repeat (2) @(posedge forever_cpuclk);
    #1;
    out_zero("reset");
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;

    // basic miss, allocate, hit
    lookup("cold_miss", 16'h1234, 1'b0, 1'b0, 16'h0);
    train("alloc_1234", 16'h1234, 16'h5678, 1'b1, 1'b0);
    lookup("hit_1234", 16'h1234, 1'b1, 1'b1, 16'h5678);

    // not-taken decrements with saturation at 0; target kept
    step("nt1", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'h5678, 1'b1);
    step("nt2", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b1);
    step("nt3", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b1);
    lookup("cnt_floor", 16'h1234, 1'b1, 1'b0, 16'h5678);

    // four taken increments, saturating at 3
    step("t1", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 16'h5678, 1'b1);
    step("t2", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 16'h5678, 1'b1);
    step("t3", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b1);
    step("t4", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b1);
    step("t5_newtgt", 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'h9ABC, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b1);
    lookup("cnt_ceiling", 16'h1234, 1'b1, 1'b1, 16'h9ABC);

    // flush with same-cycle lookup sees pre-flush state
    step("inv_lookup", 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h9ABC, 1'b0);
    lookup("post_inv", 16'h1234, 1'b0, 1'b0, 16'h0);

    // fill, then round-robin replacement
    for (int i = 0; i < 8; i++) train("fill", 16'(i), 16'h0100 + 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) lookup("fill_hit", 16'(i), 1'b1, 1'b1, 16'h0100 + 16'(i));
    train("alloc_8", 16'h0008, 16'h0108, 1'b1, 1'b0);
    lookup("evicted_0", 16'h0000, 1'b0, 1'b0, 16'h0);
    lookup("hit_8", 16'h0008, 1'b1, 1'b1, 16'h0108);
    train("alloc_9", 16'h0009, 16'h0109, 1'b1, 1'b0);
    lookup("evicted_1", 16'h0001, 1'b0, 1'b0, 16'h0);
    lookup("hit_9", 16'h0009, 1'b1, 1'b1, 16'h0109);
    lookup("kept_2", 16'h0002, 1'b1, 1'b1, 16'h0102);

    // flush beats a same-cycle hit update and a same-cycle allocation
    step("inv_vs_hit", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0002, 16'h0F00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step("inv_vs_alloc", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'hAAAA, 16'h0BBB, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    lookup("miss_AAAA", 16'hAAAA, 1'b0, 1'b0, 16'h0);
    lookup("miss_2", 16'h0002, 1'b0, 1'b0, 16'h0);
    lookup("miss_8", 16'h0008, 1'b0, 1'b0, 16'h0);

    // flush also resets the rr pointer
    for (int i = 0; i < 8; i++) train("refill", 16'(i), 16'h0100 + 16'(i), 1'b1, 1'b0);
    train("alloc_20", 16'h0020, 16'h0120, 1'b1, 1'b0);
    lookup("rr_reset_ev0", 16'h0000, 1'b0, 1'b0, 16'h0);
    lookup("rr_reset_kept2", 16'h0002, 1'b1, 1'b1, 16'h0102);
    lookup("hit_20", 16'h0020, 1'b1, 1'b1, 16'h0120);

    // disabled: lookup forced to miss, hit training still applies, no allocation
    step("dis_hit_upd", 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0001, 16'h0777, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    lookup("dis_upd_seen", 16'h0001, 1'b1, 1'b1, 16'h0777);
    step("dis_no_alloc", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h00F0, 16'h00F1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    lookup("dis_miss_F0", 16'h00F0, 1'b0, 1'b0, 16'h0);
    step("rd_vld_low", 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    train("nt_miss", 16'h00EE, 16'h00EF, 1'b0, 1'b0);
    lookup("nt_miss_none", 16'h00EE, 1'b0, 1'b0, 16'h0);

    // same-cycle lookup and allocation of a new tag (victim is entry 1 via rr)
    step("same_cycle", 1'b1, 1'b0, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 16'h0ABC, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    lookup("same_cycle_next", 16'h00FF, 1'b1, 1'b1, 16'h0ABC);
    lookup("evicted_1b", 16'h0001, 1'b0, 1'b0, 16'h0);
    lookup("kept_3", 16'h0003, 1'b1, 1'b1, 16'h0103);

    // asynchronous reset mid-operation
    lookup("pre_reset", 16'h00FF, 1'b1, 1'b1, 16'h0ABC);
    @(negedge forever_cpuclk);
    btb.btb_rd_vld = 1'b0;
    #1 cpurst_b = 1'b0;
    #1 out_zero("async_reset");
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    lookup("post_reset_FF", 16'h00FF, 1'b0, 1'b0, 16'h0);
    lookup("post_reset_3", 16'h0003, 1'b0, 1'b0, 16'h0);

    cmp("scoreboard", "pending", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
